// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared definitions for the mm:ss stopwatch.
//   status_e : run-status encoding, which is also the FSM state register value
//   SEC_MAX  : last seconds value before the seconds field wraps
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } status_e;

  localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter -- mm:ss elapsed-time register with wrap arithmetic.
// Ports:
//   clk     in   system clock (posedge)
//   rst     in   synchronous active-high reset, clears to 00:00
//   clear   in   soft clear to 00:00, wins over tick
//   tick    in   advance one second this cycle
//   minutes out  8-bit binary minutes, 0..MAX_MIN
//   seconds out  6-bit binary seconds, 0..59
// At MAX_MIN:59 the next tick wraps to 00:00; there is no saturation.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  output logic [7:0] minutes,
  output logic [5:0] seconds
);

  logic [7:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;

  always_comb begin
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (clear) begin
      minutes_d = 8'd0;
      seconds_d = 6'd0;
    end else if (tick) begin
      if (seconds_q == SEC_MAX) begin
        seconds_d = 6'd0;
        if (minutes_q == 8'(MAX_MIN)) begin
          minutes_d = 8'd0;
        end else begin
          minutes_d = minutes_q + 8'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      minutes_q <= 8'd0;
      seconds_q <= 6'd0;
    end else begin
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign minutes = minutes_q;
  assign seconds = seconds_q;

endmodule

// File: rtl/stopwatch.sv
// stopwatch -- minutes/seconds stopwatch with start, stop and soft clear.
// Ports:
//   clk     in   system clock (posedge)
//   rst     in   synchronous active-high global reset
//   start   in   start/resume pulse (one cycle)
//   stop    in   pause pulse (one cycle)
//   reset   in   soft clear pulse (one cycle)
//   minutes out  elapsed minutes, 0..MAX_MIN
//   seconds out  elapsed seconds, 0..59
//   status  out  registered FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED
// Build option: define STOPWATCH_PRESCALE_EN to count one second per CLK_HZ
// cycles. Without it the count advances every cycle while RUNNING.
// Control priority each cycle: rst > reset > stop > start. All inputs are
// level-sampled single-cycle pulses; there is no handshake, and every output
// comes straight from a flop.
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status
);

  status_e state_q, state_d;
  logic    running;
  logic    advance;
  logic    tick;

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUNNING) state_d = ST_PAUSED;
    end else if (start) begin
      if (state_q != ST_RUNNING) state_d = ST_RUNNING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The count moves only out of a registered RUNNING state, so the cycle that
  // samples start does not count, and the cycle that samples stop or reset
  // does not count either.
  assign running = (state_q == ST_RUNNING);
  assign advance = running && !stop && !reset;

`ifdef STOPWATCH_PRESCALE_EN
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          presc_last;

  assign presc_last = (presc_q == PW'(CLK_HZ - 1));

  // Held while paused; cleared by soft clear so a restart begins a full second.
  always_comb begin
    presc_d = presc_q;
    if (reset) begin
      presc_d = '0;
    end else if (advance) begin
      presc_d = presc_last ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign tick = advance && presc_last;
`else
  // One second per cycle; a non-positive CLK_HZ is meaningless and stops the
  // count rather than pretending to be a rate.
  assign tick = advance && (CLK_HZ > 0);
`endif

  stopwatch_time_counter #(
    .MAX_MIN (MAX_MIN)
  ) u_time_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (reset),
    .tick    (tick),
    .minutes (minutes),
    .seconds (seconds)
  );

  assign status = state_q;

endmodule

// File: tb/tb_stopwatch.sv
// tb_stopwatch -- directed bench for stopwatch (build without prescaler).
// A table of per-cycle {start, stop, reset} inputs with expected mm:ss/status
// covers control priority; hand-written sequences cover the long runs, resume,
// soft clear while running and the 99:59 -> 00:00 wrap.
module tb_stopwatch;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       reset;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_PSE  = 2'b10;

  stopwatch #(
    .CLK_HZ  (100_000_000),
    .MAX_MIN (99)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .reset   (reset),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic expect_now(input string name, input int m, input int s,
                            input logic [1:0] st);
    logic [15:0] exp;
    exp_q.push_back({8'(m), 6'(s), st});
    exp = exp_q.pop_front();
    n_tests++;
    if ({minutes, seconds, status} !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d status %b, expected %0d:%0d status %b",
               name, minutes, seconds, status, exp[15:8], exp[7:2], exp[1:0]);
    end
  endtask

  // ---------------- drivers ----------------
  // Apply inputs for one clock edge; outputs are then sampled 1 time unit later.
  task automatic cycle(input logic s, input logic p, input logic r);
    @(negedge clk);
    start = s;
    stop  = p;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       stop;
    logic       reset;
    int         exp_min;
    int         exp_sec;
    logic [1:0] exp_st;
    string      name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;

    // Starting from IDLE 00:00 after reset.
    vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 0, S_IDLE, "stop_in_idle"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 0, S_IDLE, "start_stop_idle"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 0, S_RUN,  "start_from_idle"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 1, S_RUN,  "first_increment"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 2, S_RUN,  "start_in_running"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 0, 2, S_PSE,  "start_stop_running"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 2, S_PSE,  "paused_hold"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 2, S_PSE,  "stop_in_paused"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 2, S_RUN,  "resume"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 3, S_RUN,  "resume_count"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 3, S_PSE,  "stop_running"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 0, 0, S_IDLE, "start_reset_paused"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 0, S_IDLE, "idle_after_clear"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 0, S_RUN,  "start_again"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 1, S_RUN,  "count_again"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 0, 0, S_IDLE, "stop_reset_running"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 0, 0, S_IDLE, "stop_reset_idle"});

    // rst for two cycles
    repeat (2) begin
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
    end
    expect_now("rst_state", 0, 0, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    expect_now("idle_no_start", 0, 0, S_IDLE);

    // Table-driven control priority checks
    foreach (vecs[i]) begin
      cycle(vecs[i].start, vecs[i].stop, vecs[i].reset);
      expect_now(vecs[i].name, vecs[i].exp_min, vecs[i].exp_sec, vecs[i].exp_st);
    end

    // Start, run 100 cycles -> 01:40
    cycle(1'b1, 1'b0, 1'b0);
    expect_now("start_edge", 0, 0, S_RUN);
    idle(100);
    expect_now("run_100", 1, 40, S_RUN);
    cycle(1'b0, 1'b1, 1'b0);
    expect_now("stop_edge", 1, 40, S_PSE);
    idle(10);
    expect_now("paused_10", 1, 40, S_PSE);

    // Resume from 01:40
    cycle(1'b1, 1'b0, 1'b0);
    expect_now("resume_edge", 1, 40, S_RUN);
    idle(5);
    expect_now("resume_5", 1, 45, S_RUN);

    // Soft clear while running lands in IDLE
    cycle(1'b0, 1'b0, 1'b1);
    expect_now("reset_running", 0, 0, S_IDLE);
    idle(5);
    expect_now("reset_idle_5", 0, 0, S_IDLE);
    cycle(1'b1, 1'b0, 1'b0);
    idle(10);
    expect_now("restart_10", 0, 10, S_RUN);

    // Wrap: advance from 00:10 to 98:59, then 61 more cycles
    idle(98 * 60 + 59 - 10);
    expect_now("reach_98_59", 98, 59, S_RUN);
    idle(1);
    expect_now("wrap_to_99_00", 99, 0, S_RUN);
    idle(59);
    expect_now("reach_99_59", 99, 59, S_RUN);
    idle(1);
    expect_now("wrap_to_00_00", 0, 0, S_RUN);
    idle(1);
    expect_now("after_wrap", 0, 1, S_RUN);

    // rst mid-run
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_now("rst_running", 0, 0, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    expect_now("rst_stays_idle", 0, 0, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
